core_bus_ram: RTL and testbench

Word-addressed RAM responder for the core's external memory bus: the target end of the interface the CPU core drives with `bus_start`, `bus_write`, `bus_addr`, `bus_data_wr` and `bus_data_be`. The block captures each request, inserts a fixed number of wait states and completes it with a one-cycle `bus_ready` pulse, returning read data or committing byte-masked write data. Requests that fall outside the RAM window complete normally and also raise a sticky fault flag.

---
 rtl/core_bus_ram.sv | 108 ++++++++++
 tb/tb_core_bus_ram.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/core_bus_ram.sv
// core_bus_ram: word-addressed RAM target for the core memory bus.
// Fixed wait-state latency, one-cycle bus_ready pulse, sticky fault on out-of-range or protocol violation.
module core_bus_ram #(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WAIT       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic              bus_start,
    input  logic              bus_write,
    input  logic [31:0]       bus_data_wr,
    input  logic [3:0]        bus_data_be,
    output logic              bus_ready,
    output logic [31:0]       bus_data_rd,
    output logic              fault
);
    localparam int unsigned DEPTH    = 2 ** DEPTH_LOG2;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic [ADDR_W-1:0]     addr_q;
    logic                  write_q;
    logic [31:0]           data_q;
    logic [3:0]            be_q;
    logic [31:0]           mem [DEPTH];

    logic                  accept;
    logic                  q_in_range;
    logic [DEPTH_LOG2-1:0] q_idx;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_in_range;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  rd_issue;

    assign accept      = (state == S_IDLE) && bus_start;
    assign q_in_range  = (addr_q[ADDR_W-1:DEPTH_LOG2] == '0);
    assign q_idx       = addr_q[DEPTH_LOG2-1:0];
    // With zero wait states the read launches on the capture edge, before addr_q holds the address.
    assign rd_addr     = (state == S_IDLE) ? bus_addr : addr_q;
    assign rd_in_range = (rd_addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign rd_idx      = rd_addr[DEPTH_LOG2-1:0];
    assign rd_issue    = (state_nx == S_RESP);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_IDLE: begin
                if (bus_start) begin
                    cnt_nx   = WAIT_CNT;
                    state_nx = (WAIT_CNT == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            data_q      <= '0;
            be_q        <= '0;
            bus_ready   <= 1'b0;
            bus_data_rd <= '0;
            fault       <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            bus_ready <= rd_issue;
            if (accept) begin
                addr_q  <= bus_addr;
                write_q <= bus_write;
                data_q  <= bus_data_wr;
                be_q    <= bus_data_be;
            end
            bus_data_rd <= (rd_issue && rd_in_range) ? mem[rd_idx] : '0;
            if ((bus_start && (state != S_IDLE)) || ((state == S_RESP) && !q_in_range)) begin
                fault <= 1'b1;
            end
        end
    end

    // Commit happens on the edge that ends RESP; a reset in that cycle still aborts it.
    always_ff @(posedge clk) begin
        if (!rst && (state == S_RESP) && write_q && q_in_range) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[q_idx][8*i +: 8] <= data_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_core_bus_ram.sv
// Scoreboard bench for core_bus_ram: one instance with WAIT=2, one with WAIT=0,
// directed scenarios followed by randomized traffic against a word-array reference model.
module tb_core_bus_ram;
    localparam int unsigned AW = 12;
    localparam int unsigned DL = 10;

    typedef struct {
        int unsigned due;
        bit          chk;
        logic [31:0] data;
        bit          flt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst   [2];
    logic          start [2];
    logic          wr    [2];
    logic [AW-1:0] addr  [2];
    logic [31:0]   wdata [2];
    logic [3:0]    be    [2];
    logic          rdy   [2];
    logic [31:0]   rdata [2];
    logic          flt   [2];

    logic [31:0]   model [2][1024];
    bit            known [2][1024];
    bit            fmodel[2];
    exp_t          q0[$];
    exp_t          q1[$];
    int unsigned   cyc = 0;
    int            checks = 0;
    int            failures = 0;

    core_bus_ram #(.ADDR_W(AW), .DEPTH_LOG2(DL), .WAIT(2)) u_w2 (
        .clk(clk), .rst(rst[0]), .bus_addr(addr[0]), .bus_start(start[0]),
        .bus_write(wr[0]), .bus_data_wr(wdata[0]), .bus_data_be(be[0]),
        .bus_ready(rdy[0]), .bus_data_rd(rdata[0]), .fault(flt[0]));

    core_bus_ram #(.ADDR_W(AW), .DEPTH_LOG2(DL), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst[1]), .bus_addr(addr[1]), .bus_start(start[1]),
        .bus_write(wr[1]), .bus_data_wr(wdata[1]), .bus_data_be(be[1]),
        .bus_ready(rdy[1]), .bus_data_rd(rdata[1]), .fault(flt[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int unsigned wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat, input logic [3:0] b);
        logic [31:0] m;
        m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (old & ~m) | (dat & m);
    endfunction

    task automatic junk(input int d);
        wr[d]    = 1'($urandom);
        addr[d]  = AW'($urandom);
        wdata[d] = $urandom;
        be[d]    = 4'($urandom);
    endtask

    task automatic txn(input int d, input bit w, input logic [AW-1:0] a, input logic [31:0] dat,
                       input logic [3:0] b, input bit viol, input int gap);
        exp_t        e;
        int unsigned wt;
        bit          inr;
        int          idx;
        int          rest;
        wt  = wait_of(d);
        inr = (a < 1024);
        idx = int'(a[9:0]);
        e.due  = cyc + 1 + wt;
        e.chk  = !w && (!inr || known[d][idx]);
        e.data = inr ? model[d][idx] : 32'h0;
        e.flt  = fmodel[d] | (viol && (wt >= 2));
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        if (w && inr) begin
            model[d][idx] = merge(known[d][idx] ? model[d][idx] : 32'h0, dat, b);
            if (b == 4'hF) known[d][idx] = 1'b1;
        end
        start[d] = 1'b1; wr[d] = w; addr[d] = a; wdata[d] = dat; be[d] = b;
        @(posedge clk); #1;
        start[d] = 1'b0;
        junk(d);
        rest = int'(wt) + 1;
        if (viol) begin
            start[d] = 1'b1;
            @(posedge clk); #1;
            start[d] = 1'b0;
            junk(d);
            fmodel[d] = 1'b1;
            rest--;
        end
        repeat (rest) begin @(posedge clk); #1; end
        if (!inr) fmodel[d] = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic abort_write(input int d, input logic [AW-1:0] a, input logic [31:0] dat);
        start[d] = 1'b1; wr[d] = 1'b1; addr[d] = a; wdata[d] = dat; be[d] = 4'hF;
        @(posedge clk); #1;
        start[d] = 1'b0;
        rst[d]   = 1'b1;
        @(posedge clk); #1;
        rst[d]    = 1'b0;
        fmodel[d] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic mon(input int d);
        exp_t e;
        bit   have;
        if (rst[d]) return;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (d == 0) ? q0[0] : q1[0];
        if (rdy[d]) begin
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready[%0d]: got ready=1 expected no response (cycle %0d)", d, cyc);
            end else begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                check($sformatf("ready_cycle[%0d]", d), cyc, e.due);
                if (e.chk) check($sformatf("read_data[%0d]", d), rdata[d], e.data);
                check($sformatf("fault_at_ready[%0d]", d), 32'(flt[d]), 32'(e.flt));
            end
        end else begin
            check($sformatf("rd_zero_idle[%0d]", d), rdata[d], 32'h0);
            if (have && cyc > e.due) begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                checks++;
                failures++;
                $display("FAIL missing_ready[%0d]: got no ready expected ready at cycle %0d", d, e.due);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; fmodel[d] = 1'b0;
            junk(d);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ready[%0d]", d), 32'(rdy[d]), 32'h0);
            check($sformatf("reset_rdata[%0d]", d), rdata[d], 32'h0);
            check($sformatf("reset_fault[%0d]", d), 32'(flt[d]), 32'h0);
            rst[d] = 1'b0;
        end
        @(posedge clk); #1;

        // WAIT=2: write/read, byte masking, empty mask, reset abort, out-of-range, violation
        txn(0, 1, 12'h005, 32'hDEADBEEF, 4'hF, 0, 0);
        txn(0, 0, 12'h005, 32'h0, 4'hF, 0, 0);
        txn(0, 1, 12'h005, 32'h11223344, 4'b0101, 0, 1);
        txn(0, 0, 12'h005, 32'h0, 4'hF, 0, 0);
        txn(0, 1, 12'h005, 32'h99887766, 4'b0000, 0, 0);
        txn(0, 0, 12'h005, 32'h0, 4'hF, 0, 0);
        abort_write(0, 12'h005, 32'hCAFEF00D);
        txn(0, 0, 12'h005, 32'h0, 4'hF, 0, 0);
        txn(0, 0, 12'h400, 32'h0, 4'hF, 0, 0);
        txn(0, 0, 12'h005, 32'h0, 4'hF, 0, 1);
        txn(0, 1, 12'h006, 32'h01020304, 4'hF, 0, 0);
        txn(0, 0, 12'h006, 32'h0, 4'hF, 1, 0);
        txn(0, 0, 12'h005, 32'h0, 4'hF, 0, 0);

        // WAIT=0: back-to-back reads two cycles apart
        txn(1, 1, 12'h007, 32'hA5A55A5A, 4'hF, 0, 0);
        txn(1, 0, 12'h007, 32'h0, 4'hF, 0, 0);
        txn(1, 0, 12'h007, 32'h0, 4'hF, 0, 0);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) txn(d, 1, AW'(i), $urandom, 4'hF, 0, 0);
            for (int n = 0; n < 80; n++) begin
                logic [AW-1:0] a;
                a = ($urandom_range(7, 0) == 0) ? AW'($urandom_range(4095, 1024)) : AW'($urandom_range(15, 0));
                txn(d, 1'($urandom), a, $urandom, 4'($urandom), (d == 0) && ($urandom_range(15, 0) == 0),
                    int'($urandom_range(2, 0)));
            end
        end

        repeat (5) begin @(posedge clk); #1; end
        for (int d = 0; d < 2; d++) check($sformatf("final_fault[%0d]", d), 32'(flt[d]), 32'(fmodel[d]));
        check("pending_w2", q0.size(), 32'h0);
        check("pending_w0", q1.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
